// File: rtl/axi4_rd_req_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axi4_rd_req_rr_arbiter
// Round-robin read-address arbiter for one master port of the AXI4 crossbar.
// It grants one qualified slave-port request at a time. The grant is
// registered, one-hot, and held until the address handshake completes. A
// credit counter tracks outstanding reads and blocks new grants at the limit.
//
// Ports
//   ACLK          : clock, rising edge
//   sysReset      : synchronous active-low reset
//   REQ           : qualified request per slave port
//   GRANT_ACK     : VALID&READY handshake of the granted request
//   TXN_DONE      : one-cycle pulse per completed read transaction
//   GRANT_VALID   : a grant is active
//   GRANT         : one-hot grant vector (zero when idle)
//   GRANT_ENC     : binary index of the granted port (zero when idle)
//   OUTSTANDING   : accepted-but-uncompleted transaction count
//   CREDIT_FULL   : OUTSTANDING == MAX_OUTSTANDING
//   ERR_UNDERFLOW : sticky, TXN_DONE seen with nothing outstanding
// ---------------------------------------------------------------------------
module axi4_rd_req_rr_arbiter #(
    parameter int unsigned NUM_SLAVES       = 8,
    parameter int unsigned NUM_SLAVES_WIDTH = 3,
    parameter int unsigned MAX_OUTSTANDING  = 8,
    parameter int unsigned CNT_WIDTH        = 4
) (
    input  logic                        ACLK,
    input  logic                        sysReset,
    input  logic [NUM_SLAVES-1:0]       REQ,
    input  logic                        GRANT_ACK,
    input  logic                        TXN_DONE,
    output logic                        GRANT_VALID,
    output logic [NUM_SLAVES-1:0]       GRANT,
    output logic [NUM_SLAVES_WIDTH-1:0] GRANT_ENC,
    output logic [CNT_WIDTH-1:0]        OUTSTANDING,
    output logic                        CREDIT_FULL,
    output logic                        ERR_UNDERFLOW
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } state_t;

    localparam logic [NUM_SLAVES_WIDTH-1:0] LAST_IDX = NUM_SLAVES_WIDTH'(NUM_SLAVES - 1);
    localparam logic [CNT_WIDTH-1:0]        CNT_MAX  = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [NUM_SLAVES-1:0]       ONE_HOT0 = NUM_SLAVES'(1);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic                        r_grant_valid;
    logic [NUM_SLAVES-1:0]       r_grant;
    logic [NUM_SLAVES_WIDTH-1:0] r_grant_enc;
    logic [NUM_SLAVES_WIDTH-1:0] r_ptr;
    logic [CNT_WIDTH-1:0]        r_cnt;
    logic                        r_err;

    logic                        w_grant_valid_nxt;
    logic [NUM_SLAVES-1:0]       w_grant_nxt;
    logic [NUM_SLAVES_WIDTH-1:0] w_grant_enc_nxt;
    logic [NUM_SLAVES_WIDTH-1:0] w_ptr_nxt;
    logic [CNT_WIDTH-1:0]        w_cnt_nxt;
    logic                        w_err_nxt;

    logic                        w_win_found;
    logic [NUM_SLAVES_WIDTH-1:0] w_win_idx;
    logic [NUM_SLAVES_WIDTH-1:0] w_scan;
    logic                        w_credit_ok;
    logic                        w_can_grant;
    logic                        w_ack;

    // Winner search: first set REQ bit from the pointer upward, wrapping.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_scan      = r_ptr;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!w_win_found && REQ[w_scan]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_scan;
            end
            w_scan = (w_scan == LAST_IDX) ? '0 : w_scan + NUM_SLAVES_WIDTH'(1);
        end
    end

    assign w_credit_ok = (r_cnt < CNT_MAX);
    assign w_can_grant = w_win_found && w_credit_ok;
    // A handshake only counts while a grant is actually held.
    assign w_ack       = (r_state == ST_GRANTED) && GRANT_ACK;

    // State and registered outputs.
    always_ff @(posedge ACLK) begin
        if (!sysReset) begin
            r_state       <= ST_IDLE;
            r_grant_valid <= 1'b0;
            r_grant       <= '0;
            r_grant_enc   <= '0;
            r_ptr         <= '0;
            r_cnt         <= '0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_enc   <= w_grant_enc_nxt;
            r_ptr         <= w_ptr_nxt;
            r_cnt         <= w_cnt_nxt;
            r_err         <= w_err_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_can_grant) w_state_nxt = ST_GRANTED;
            ST_GRANTED: if (GRANT_ACK)   w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, pointer and credit counter.
    always_comb begin
        w_grant_valid_nxt = r_grant_valid;
        w_grant_nxt       = r_grant;
        w_grant_enc_nxt   = r_grant_enc;
        w_ptr_nxt         = r_ptr;
        w_cnt_nxt         = r_cnt;
        w_err_nxt         = r_err;

        case (r_state)
            ST_IDLE: begin
                if (w_can_grant) begin
                    w_grant_valid_nxt = 1'b1;
                    w_grant_nxt       = ONE_HOT0 << w_win_idx;
                    w_grant_enc_nxt   = w_win_idx;
                end
            end
            ST_GRANTED: begin
                // Grant is held even if the granted REQ bit drops.
                if (GRANT_ACK) begin
                    w_grant_valid_nxt = 1'b0;
                    w_grant_nxt       = '0;
                    w_grant_enc_nxt   = '0;
                    w_ptr_nxt         = (r_grant_enc == LAST_IDX) ? '0
                                        : r_grant_enc + NUM_SLAVES_WIDTH'(1);
                end
            end
            default: begin
                w_grant_valid_nxt = 1'b0;
                w_grant_nxt       = '0;
                w_grant_enc_nxt   = '0;
            end
        endcase

        // Simultaneous accept and completion cancel out.
        if (w_ack && !TXN_DONE) begin
            w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end else if (!w_ack && TXN_DONE) begin
            if (r_cnt == '0) begin
                w_err_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
            end
        end
    end

    assign GRANT_VALID   = r_grant_valid;
    assign GRANT         = r_grant;
    assign GRANT_ENC     = r_grant_enc;
    assign OUTSTANDING   = r_cnt;
    assign CREDIT_FULL   = (r_cnt == CNT_MAX);
    assign ERR_UNDERFLOW = r_err;

endmodule

// File: tb/tb_axi4_rd_req_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi4_rd_req_rr_arbiter
// Directed bench for the round-robin read arbiter. Instance "dut" uses the
// default credit limit of 8; instance "dut2" uses a limit of 2 for the
// credit-exhaustion scenario. Inputs change and outputs are sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_axi4_rd_req_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       ack;
    logic       done;
    logic       gv;
    logic [7:0] gnt;
    logic [2:0] enc;
    logic [3:0] cnt;
    logic       full;
    logic       err;

    logic [7:0] b_req;
    logic       b_ack;
    logic       b_done;
    logic       b_gv;
    logic [7:0] b_gnt;
    logic [2:0] b_enc;
    logic [1:0] b_cnt;
    logic       b_full;
    logic       b_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi4_rd_req_rr_arbiter dut (
        .ACLK(clk), .sysReset(rst_n), .REQ(req), .GRANT_ACK(ack), .TXN_DONE(done),
        .GRANT_VALID(gv), .GRANT(gnt), .GRANT_ENC(enc), .OUTSTANDING(cnt),
        .CREDIT_FULL(full), .ERR_UNDERFLOW(err)
    );

    axi4_rd_req_rr_arbiter #(
        .NUM_SLAVES(8), .NUM_SLAVES_WIDTH(3), .MAX_OUTSTANDING(2), .CNT_WIDTH(2)
    ) dut2 (
        .ACLK(clk), .sysReset(rst_n), .REQ(b_req), .GRANT_ACK(b_ack), .TXN_DONE(b_done),
        .GRANT_VALID(b_gv), .GRANT(b_gnt), .GRANT_ENC(b_enc), .OUTSTANDING(b_cnt),
        .CREDIT_FULL(b_full), .ERR_UNDERFLOW(b_err)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_gv"},  32'(gv),  32'd0);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_enc"}, 32'(enc), 32'd0);
    endtask

    task automatic check_grant_a(input string tag, input int idx);
        check({tag, "_gv"},  32'(gv),  32'd1);
        check({tag, "_gnt"}, 32'(gnt), 32'd1 << idx);
        check({tag, "_enc"}, 32'(enc), 32'(idx));
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = '0;
        ack    = 1'b0;
        done   = 1'b0;
        b_req  = '0;
        b_ack  = 1'b0;
        b_done = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check_idle_a("rst");
        check("rst_cnt",  32'(cnt),  32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_err",  32'(err),  32'd0);

        // Single request on port 2, grant held when REQ drops
        req = 8'h04;
        tick();
        check_grant_a("p2", 2);
        req = 8'h00;
        tick();
        check_grant_a("p2_hold", 2);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_idle_a("p2_ack");
        check("p2_cnt", 32'(cnt), 32'd1);

        // Round robin over all ports with completion overlapping each accept
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            tick();
            check_grant_a($sformatf("rr%0d", k), k % 8);
            ack  = 1'b1;
            done = (k > 0);
            tick();
            ack  = 1'b0;
            done = 1'b0;
            check($sformatf("rr%0d_cnt", k), 32'(cnt), 32'd1);
            check($sformatf("rr%0d_gv", k),  32'(gv),  32'd0);
        end
        req = 8'h00;

        // Move pointer to 6, then wrap-around to 0 and 1
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 8'h20;
        tick();
        check_grant_a("p5", 5);
        ack = 1'b1;
        req = 8'h03;
        tick();
        ack = 1'b0;
        tick();
        check_grant_a("wrap0", 0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        check_grant_a("wrap1", 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("wrap_cnt", 32'(cnt), 32'd3);

        // Pointer now 2: port 0 wins; accept and completion together at 3
        tick();
        check_grant_a("p0_from2", 0);
        ack  = 1'b1;
        done = 1'b1;
        req  = 8'h00;
        tick();
        ack  = 1'b0;
        done = 1'b0;
        check("both_cnt", 32'(cnt), 32'd3);
        check("both_gv",  32'(gv),  32'd0);

        // Handshake while idle is ignored
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("idle_ack_cnt", 32'(cnt), 32'd3);
        check("idle_ack_gv",  32'(gv),  32'd0);

        // Drain, then underflow
        done = 1'b1;
        tick();
        tick();
        tick();
        check("drain_cnt", 32'(cnt), 32'd0);
        check("drain_err", 32'(err), 32'd0);
        tick();
        done = 1'b0;
        check("uf_cnt", 32'(cnt), 32'd0);
        check("uf_err", 32'(err), 32'd1);
        tick();
        check("uf_sticky", 32'(err), 32'd1);

        // Reset while granted at port 5
        req = 8'h20;
        tick();
        check_grant_a("pre_rst", 5);
        rst_n = 1'b0;
        tick();
        check_idle_a("mid_rst");
        check("mid_rst_cnt", 32'(cnt), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        req   = 8'h21;
        tick();
        check_grant_a("post_rst", 0);
        req = 8'h00;

        // Credit limit of 2 on the second instance
        b_req = 8'h01;
        tick();
        check("cr_g1", 32'(b_gv), 32'd1);
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        check("cr_c1",  32'(b_cnt),  32'd1);
        check("cr_f1",  32'(b_full), 32'd0);
        tick();
        check("cr_g2", 32'(b_gv), 32'd1);
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        check("cr_c2", 32'(b_cnt),  32'd2);
        check("cr_f2", 32'(b_full), 32'd1);
        tick();
        tick();
        check("cr_blocked", 32'(b_gv), 32'd0);
        b_done = 1'b1;
        tick();
        b_done = 1'b0;
        check("cr_c_dec", 32'(b_cnt),  32'd1);
        check("cr_f_dec", 32'(b_full), 32'd0);
        tick();
        check("cr_g3",     32'(b_gv),  32'd1);
        check("cr_g3_gnt", 32'(b_gnt), 32'd1);
        // Completion in the same cycle the count would reach full
        b_ack  = 1'b1;
        b_done = 1'b1;
        tick();
        b_ack  = 1'b0;
        b_done = 1'b0;
        check("cr_both_cnt",  32'(b_cnt),  32'd1);
        check("cr_both_full", 32'(b_full), 32'd0);
        tick();
        check("cr_g4", 32'(b_gv), 32'd1);
        check("cr_err", 32'(b_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
